rv32_id_ex_reg: RTL and testbench

RV32_ID_EX_REG -- requirements
Module: rv32_id_ex_reg

---
 rtl/rv32_pkg.sv | 19 +
 rtl/rv32_fwd_mux.sv | 32 +++
 rtl/rv32_id_ex_reg.sv | 119 +++++++++++
 tb/tb_rv32_id_ex_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared widths and ALU opcode encodings for the RV32 ID/EX slice.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OPCODE_W   = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_SLT  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SLTU = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_SLL  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_SRA  = 4'b1101;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0111;

endpackage

// File: rtl/rv32_fwd_mux.sv
// Three-way operand select: EX result, then WB data, then register-file data.
module rv32_fwd_mux
  import rv32_pkg::*;
#(
  parameter int W = rv32_pkg::XLEN
) (
  input  logic                  i_fwd_en,
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic                  i_ex_wr,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [W-1:0]          i_ex_data,
  input  logic                  i_wb_wr,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [W-1:0]          i_wb_data,
  input  logic [W-1:0]          i_rf_data,
  output logic [W-1:0]          o_data
);

  always_comb begin
    // NOTE: default first so every path assigns o_data and no latch is inferred.
    o_data = i_rf_data;
    // x0 is hardwired to zero, so a pending write to it must never be forwarded.
    if (i_fwd_en && (i_rs_addr != '0)) begin
      if (i_ex_wr && (i_ex_rd == i_rs_addr)) begin
        o_data = i_ex_data;
      end else if (i_wb_wr && (i_wb_rd == i_rs_addr)) begin
        o_data = i_wb_data;
      end
    end
  end

endmodule

// File: rtl/rv32_id_ex_reg.sv
// ID/EX pipeline slot with valid/ready handshake, flush and operand forwarding.
// Forwarding is built only when RV32_FWD_EN is defined; otherwise operands come from the register file.
module rv32_id_ex_reg
  import rv32_pkg::*;
#(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [REG_ADDR_W-1:0] rs1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs2_addr_in,
  input  logic [XLEN-1:0]       rs1_data_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic                  op2_imm_in,
  input  logic [OPCODE_W-1:0]   opcode_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  reg_wr_in,
  input  logic                  flush_in,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_in,
  input  logic                  ex_reg_wr_in,
  input  logic [XLEN-1:0]       ex_result_in,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_in,
  input  logic                  wb_reg_wr_in,
  input  logic [XLEN-1:0]       wb_data_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [XLEN-1:0]       op_1_out,
  output logic [XLEN-1:0]       op_2_out,
  output logic [OPCODE_W-1:0]   opcode_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  reg_wr_out
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_op1;
  logic [XLEN-1:0]       r_op2;
  logic [OPCODE_W-1:0]   r_opcode;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_wr;

  logic                  w_in_ready;
  logic                  w_capture;
  logic                  w_fwd1_en;
  logic                  w_fwd2_en;
  logic [XLEN-1:0]       w_op1;
  logic [XLEN-1:0]       w_op2;

  assign w_in_ready = !r_valid || out_ready_in;
  assign w_capture  = in_valid_in && w_in_ready && !flush_in;

`ifdef RV32_FWD_EN
  assign w_fwd1_en = 1'b1;
  assign w_fwd2_en = !op2_imm_in;
`else
  assign w_fwd1_en = 1'b0;
  assign w_fwd2_en = 1'b0;
`endif

  rv32_fwd_mux #(.W(XLEN)) u_fwd_op1 (
    .i_fwd_en  (w_fwd1_en),
    .i_rs_addr (rs1_addr_in),
    .i_ex_wr   (ex_reg_wr_in),
    .i_ex_rd   (ex_rd_addr_in),
    .i_ex_data (ex_result_in),
    .i_wb_wr   (wb_reg_wr_in),
    .i_wb_rd   (wb_rd_addr_in),
    .i_wb_data (wb_data_in),
    .i_rf_data (rs1_data_in),
    .o_data    (w_op1)
  );

  rv32_fwd_mux #(.W(XLEN)) u_fwd_op2 (
    .i_fwd_en  (w_fwd2_en),
    .i_rs_addr (rs2_addr_in),
    .i_ex_wr   (ex_reg_wr_in),
    .i_ex_rd   (ex_rd_addr_in),
    .i_ex_data (ex_result_in),
    .i_wb_wr   (wb_reg_wr_in),
    .i_wb_rd   (wb_rd_addr_in),
    .i_wb_data (wb_data_in),
    .i_rf_data (rs2_data_in),
    .o_data    (w_op2)
  );

  // NOTE: datapath registers are reset too, so the outputs read as zero while in reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_valid  <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_opcode <= '0;
      r_rd     <= '0;
      r_reg_wr <= 1'b0;
    end else if (flush_in) begin
      r_valid  <= 1'b0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_op1    <= w_op1;
      r_op2    <= w_op2;
      r_opcode <= opcode_in;
      r_rd     <= rd_addr_in;
      r_reg_wr <= reg_wr_in;
    end else if (out_ready_in) begin
      r_valid  <= 1'b0;
    end
  end

  assign in_ready_out  = w_in_ready;
  assign out_valid_out = r_valid;
  assign op_1_out      = r_op1;
  assign op_2_out      = r_op2;
  assign opcode_out    = r_opcode;
  assign rd_addr_out   = r_rd;
  assign reg_wr_out    = r_valid && r_reg_wr;

endmodule

// File: tb/tb_rv32_id_ex_reg.sv
// Directed self-checking bench for rv32_id_ex_reg; expectations follow RV32_FWD_EN when defined.
module tb_rv32_id_ex_reg;
  import rv32_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic [31:0] rs1_data_in, rs2_data_in;
  logic        op2_imm_in, reg_wr_in, flush_in;
  logic [3:0]  opcode_in, opcode_out;
  logic [4:0]  ex_rd_addr_in, wb_rd_addr_in, rd_addr_out;
  logic        ex_reg_wr_in, wb_reg_wr_in;
  logic [31:0] ex_result_in, wb_data_in;
  logic        out_valid_out, out_ready_in, reg_wr_out;
  logic [31:0] op_1_out, op_2_out;

  int n_checks = 0;
  int n_pass   = 0;
  bit fwd_en;

  rv32_id_ex_reg dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .rs1_addr_in   (rs1_addr_in),
    .rs2_addr_in   (rs2_addr_in),
    .rs1_data_in   (rs1_data_in),
    .rs2_data_in   (rs2_data_in),
    .op2_imm_in    (op2_imm_in),
    .opcode_in     (opcode_in),
    .rd_addr_in    (rd_addr_in),
    .reg_wr_in     (reg_wr_in),
    .flush_in      (flush_in),
    .ex_rd_addr_in (ex_rd_addr_in),
    .ex_reg_wr_in  (ex_reg_wr_in),
    .ex_result_in  (ex_result_in),
    .wb_rd_addr_in (wb_rd_addr_in),
    .wb_reg_wr_in  (wb_reg_wr_in),
    .wb_data_in    (wb_data_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .op_1_out      (op_1_out),
    .op_2_out      (op_2_out),
    .opcode_out    (opcode_out),
    .rd_addr_out   (rd_addr_out),
    .reg_wr_out    (reg_wr_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1a, input logic [4:0] rs2a,
                       input logic [31:0] rs1d, input logic [31:0] rs2d, input logic imm,
                       input logic [3:0] opc, input logic [4:0] rd, input logic wr);
    in_valid_in = v;   rs1_addr_in = rs1a; rs2_addr_in = rs2a;
    rs1_data_in = rs1d; rs2_data_in = rs2d; op2_imm_in = imm;
    opcode_in   = opc; rd_addr_in = rd;    reg_wr_in  = wr;
  endtask

  initial begin
`ifdef RV32_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    rst_n_in = 1'b0;
    flush_in = 1'b0;
    out_ready_in = 1'b1;
    ex_rd_addr_in = '0; ex_reg_wr_in = 1'b0; ex_result_in = '0;
    wb_rd_addr_in = '0; wb_reg_wr_in = 1'b0; wb_data_in = '0;
    drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, OP_ADD, 5'd0, 1'b0);
    #1;
    check("rst_valid", out_valid_out, 0);
    check("rst_regwr", reg_wr_out, 0);
    check("rst_op1", op_1_out, 0);
    check("rst_op2", op_2_out, 0);
    check("rst_opcode", opcode_out, 0);
    check("rst_rd", rd_addr_out, 0);
    check("rst_in_ready", in_ready_out, 1);
    #11 rst_n_in = 1'b1;

    // Basic capture then drain.
    drive(1'b1, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, OP_ADD, 5'd9, 1'b1);
    step();
    check("cap_valid", out_valid_out, 1);
    check("cap_op1", op_1_out, 5);
    check("cap_op2", op_2_out, 7);
    check("cap_opcode", opcode_out, OP_ADD);
    check("cap_rd", rd_addr_out, 9);
    check("cap_regwr", reg_wr_out, 1);
    drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, OP_ADD, 5'd0, 1'b0);
    step();
    check("drain_valid", out_valid_out, 0);
    check("drain_regwr", reg_wr_out, 0);

    // Stall for three cycles, then drain and capture in the same edge.
    drive(1'b1, 5'd1, 5'd2, 32'h11, 32'h22, 1'b0, OP_SUB, 5'd2, 1'b1);
    out_ready_in = 1'b0;
    step();
    drive(1'b1, 5'd1, 5'd2, 32'h33, 32'h44, 1'b0, OP_XOR, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready_out, 0);
      step();
      check("stall_valid", out_valid_out, 1);
      check("stall_op1", op_1_out, 32'h11);
      check("stall_opcode", opcode_out, OP_SUB);
    end
    out_ready_in = 1'b1;
    #1 check("unstall_in_ready", in_ready_out, 1);
    step();
    check("nobubble_valid", out_valid_out, 1);
    check("nobubble_op1", op_1_out, 32'h33);
    check("nobubble_op2", op_2_out, 32'h44);
    check("nobubble_opcode", opcode_out, OP_XOR);

    // Forwarding priority on op1 and op2, immediate bypass, x0 never forwarded.
    ex_rd_addr_in = 5'd3; ex_reg_wr_in = 1'b1; ex_result_in = 32'hAA;
    wb_rd_addr_in = 5'd3; wb_reg_wr_in = 1'b1; wb_data_in   = 32'hBB;
    drive(1'b1, 5'd3, 5'd6, 32'h30, 32'h60, 1'b0, OP_OR, 5'd4, 1'b1);
    step();
    check("fwd_ex", op_1_out, fwd_en ? 32'hAA : 32'h30);
    ex_reg_wr_in = 1'b0;
    step();
    check("fwd_wb", op_1_out, fwd_en ? 32'hBB : 32'h30);
    ex_rd_addr_in = 5'd0; ex_reg_wr_in = 1'b1;
    wb_rd_addr_in = 5'd0;
    drive(1'b1, 5'd0, 5'd6, 32'h30, 32'h60, 1'b0, OP_OR, 5'd4, 1'b1);
    step();
    check("fwd_x0", op_1_out, 32'h30);
    ex_rd_addr_in = 5'd4;
    drive(1'b1, 5'd1, 5'd4, 32'h10, 32'h40, 1'b0, OP_AND, 5'd5, 1'b1);
    step();
    check("fwd_op2_ex", op_2_out, fwd_en ? 32'hAA : 32'h40);
    drive(1'b1, 5'd1, 5'd4, 32'h10, 32'h123, 1'b1, OP_AND, 5'd5, 1'b1);
    step();
    check("imm_no_fwd", op_2_out, 32'h123);
    ex_reg_wr_in = 1'b0; wb_reg_wr_in = 1'b0;

    // Flush with an incoming instruction while full and stalled.
    drive(1'b1, 5'd1, 5'd2, 32'h55, 32'h66, 1'b0, OP_SLT, 5'd7, 1'b1);
    out_ready_in = 1'b0;
    step();
    check("preflush_valid", out_valid_out, 1);
    drive(1'b1, 5'd1, 5'd2, 32'h77, 32'h88, 1'b0, OP_SLTU, 5'd8, 1'b1);
    flush_in = 1'b1;
    step();
    check("flush_valid", out_valid_out, 0);
    check("flush_regwr", reg_wr_out, 0);
    flush_in = 1'b0;

    // Asynchronous reset while stalled, then capture on the first edge after release.
    drive(1'b1, 5'd1, 5'd2, 32'h99, 32'h9A, 1'b0, OP_SRA, 5'd10, 1'b1);
    step();
    check("prerst_valid", out_valid_out, 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("async_rst_valid", out_valid_out, 0);
    check("async_rst_op1", op_1_out, 0);
    check("async_rst_regwr", reg_wr_out, 0);
    #2 rst_n_in = 1'b1;
    out_ready_in = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 1'b0, 4'hF, 5'd31, 1'b0);
    step();
    check("post_rst_valid", out_valid_out, 1);
    check("post_rst_op1", op_1_out, 32'hDEAD);
    check("opcode_passthru", opcode_out, 4'hF);
    check("rd_passthru", rd_addr_out, 31);
    check("regwr_zero", reg_wr_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
